// File: rtl/plic_claim_ctrl.sv
// rtl/plic_claim_ctrl.sv - PLIC claim/complete sequencer with per-target ownership tracking
// Define PLIC_CLAIM_RR_EN for round-robin claim arbitration; otherwise fixed priority (lowest target wins).
module plic_claim_ctrl #(
  parameter int SOURCES      = 8,
  parameter int TARGETS      = 1,
  parameter int CLAIM_GAP    = 2,
  parameter int SOURCES_BITS = $clog2(SOURCES+1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [TARGETS-1:0]              claim_req_i,
  output logic [TARGETS-1:0]              claim_ack_o,
  output logic [TARGETS*SOURCES_BITS-1:0] claim_id_o,
  input  logic [TARGETS-1:0]              complete_req_i,
  input  logic [TARGETS*SOURCES_BITS-1:0] complete_id_i,
  output logic [TARGETS-1:0]              complete_ack_o,
  output logic [TARGETS-1:0]              complete_err_o,
  output logic [TARGETS-1:0]              busy_o,
  input  logic [TARGETS*SOURCES_BITS-1:0] id_i,
  output logic [TARGETS-1:0]              claim_o,
  output logic [TARGETS-1:0]              complete_o
);

  localparam int IDX_W = (TARGETS > 1) ? $clog2(TARGETS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  state_e                  state_q [TARGETS];
  state_e                  state_d [TARGETS];
  logic [SOURCES_BITS-1:0] id_q    [TARGETS];
  logic [SOURCES_BITS-1:0] id_d    [TARGETS];

  logic [TARGETS-1:0]              pending_q, pending_d;
  logic [TARGETS-1:0]              claim_q, claim_d;
  logic [TARGETS-1:0]              claim_ack_q, claim_ack_d;
  logic [TARGETS*SOURCES_BITS-1:0] claim_id_q, claim_id_d;
  logic [TARGETS-1:0]              complete_q, complete_d;
  logic [TARGETS-1:0]              complete_ack_q, complete_ack_d;
  logic [TARGETS-1:0]              complete_err_q, complete_err_d;
  logic [3:0]                      gap_q, gap_d;

  logic [TARGETS-1:0]              accept;
  logic [TARGETS-1:0]              own_ack;
  logic [TARGETS-1:0]              eligible;
  logic                            found;
  int                              idx;
  int                              grant_idx;

`ifdef PLIC_CLAIM_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  always_comb begin : next_state
    pending_d      = pending_q;
    claim_d        = '0;
    claim_ack_d    = '0;
    claim_id_d     = '0;
    complete_d     = '0;
    complete_ack_d = '0;
    complete_err_d = '0;
    gap_d          = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
    accept         = '0;
    own_ack        = '0;
    eligible       = '0;
    found          = 1'b0;
    idx            = 0;
    grant_idx      = 0;
`ifdef PLIC_CLAIM_RR_EN
    ptr_d          = ptr_q;
`endif

    for (int t = 0; t < TARGETS; t++) begin
      state_d[t] = state_q[t];
      id_d[t]    = id_q[t];

      // Complete is resolved before any claim on the same target.
      accept[t] = complete_req_i[t] && (state_q[t] == OWN) &&
                  (complete_id_i[t*SOURCES_BITS +: SOURCES_BITS] == id_q[t]);
      complete_d[t]     = accept[t];
      complete_ack_d[t] = complete_req_i[t];
      complete_err_d[t] = complete_req_i[t] && !accept[t];
      if (accept[t]) begin
        state_d[t] = IDLE;
      end

      own_ack[t] = (pending_q[t] || claim_req_i[t]) && (state_q[t] == OWN) && !accept[t];

      // The cycle the core sees claim_o is the cycle its id is still valid.
      if (claim_q[t]) begin
        id_d[t]        = id_i[t*SOURCES_BITS +: SOURCES_BITS];
        claim_ack_d[t] = 1'b1;
        claim_id_d[t*SOURCES_BITS +: SOURCES_BITS] = id_i[t*SOURCES_BITS +: SOURCES_BITS];
        if (id_i[t*SOURCES_BITS +: SOURCES_BITS] != '0) begin
          state_d[t] = OWN;
        end
      end else if (own_ack[t]) begin
        claim_ack_d[t] = 1'b1;
      end

      pending_d[t] = (pending_q[t] || claim_req_i[t]) && !claim_q[t] && !own_ack[t];

      eligible[t] = (pending_q[t] || claim_req_i[t]) && (state_q[t] == IDLE) &&
                    !claim_q[t] && (gap_q == 4'd0);
    end

    for (int i = 0; i < TARGETS; i++) begin
`ifdef PLIC_CLAIM_RR_EN
      idx = int'(ptr_q) + 1 + i;
      if (idx >= TARGETS) begin
        idx = idx - TARGETS;
      end
`else
      idx = i;
`endif
      if (!found && eligible[IDX_W'(idx)]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end

    if (found) begin
      claim_d[IDX_W'(grant_idx)] = 1'b1;
      gap_d = 4'(CLAIM_GAP);
`ifdef PLIC_CLAIM_RR_EN
      ptr_d = IDX_W'(grant_idx);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      for (int t = 0; t < TARGETS; t++) begin
        state_q[t] <= IDLE;
        id_q[t]    <= '0;
      end
      pending_q      <= '0;
      claim_q        <= '0;
      claim_ack_q    <= '0;
      claim_id_q     <= '0;
      complete_q     <= '0;
      complete_ack_q <= '0;
      complete_err_q <= '0;
      gap_q          <= 4'd0;
`ifdef PLIC_CLAIM_RR_EN
      ptr_q          <= IDX_W'(TARGETS-1);
`endif
    end else begin
      for (int t = 0; t < TARGETS; t++) begin
        state_q[t] <= state_d[t];
        id_q[t]    <= id_d[t];
      end
      pending_q      <= pending_d;
      claim_q        <= claim_d;
      claim_ack_q    <= claim_ack_d;
      claim_id_q     <= claim_id_d;
      complete_q     <= complete_d;
      complete_ack_q <= complete_ack_d;
      complete_err_q <= complete_err_d;
      gap_q          <= gap_d;
`ifdef PLIC_CLAIM_RR_EN
      ptr_q          <= ptr_d;
`endif
    end
  end

  always_comb begin : busy_map
    busy_o = '0;
    for (int t = 0; t < TARGETS; t++) begin
      busy_o[t] = (state_q[t] == OWN);
    end
  end

  assign claim_o        = claim_q;
  assign claim_ack_o    = claim_ack_q;
  assign claim_id_o     = claim_id_q;
  assign complete_o     = complete_q;
  assign complete_ack_o = complete_ack_q;
  assign complete_err_o = complete_err_q;

endmodule
